// File: rtl/phy_link_pkg.sv
// Shared definitions for the receive-side link training path:
// state encodings, SKP ordered-symbol codes and small sizing helpers.
package phy_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SRST    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ALIGN   = 3'd3,
    ST_LINK_UP = 3'd4,
    ST_FAILED  = 3'd5
  } link_state_e;

  localparam logic [9:0] K_CODE_SKP_RD_N = 10'h33C;
  localparam logic [9:0] K_CODE_SKP_RD_P = 10'h0C3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_skp(input logic [9:0] w);
    return (w == K_CODE_SKP_RD_N) || (w == K_CODE_SKP_RD_P);
  endfunction

endpackage

// File: rtl/async_reset.sv
// Reset bridge: asynchronous assertion, synchronous 2-stage deassertion.
module async_reset (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) sync_q <= '0;
    else           sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/physical_link_training_ctrl_skp_monitor.sv
// SKP loss monitor: counts words since the last SKP while enabled and
// pulses timeout_o when SKP_TIMEOUT words pass without one.
module phy_skp_monitor
  import phy_link_pkg::*;
#(
  parameter int unsigned SKP_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [9:0] data_i,
  output logic       timeout_o
);

  localparam int unsigned CW = (SKP_TIMEOUT > 2) ? $clog2(SKP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SKP_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || timeout_o || is_skp(data_i)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sync_2ff.sv
// Single-bit 2-flop synchroniser for level inputs.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/physical_link_training_ctrl.sv
// Receive link training sequencer: SERDES reset, settle, word-align with
// timeout and retry, then SKP-supervised link-up with forced retraining.
module physical_link_training_ctrl
  import phy_link_pkg::*;
#(
  parameter int unsigned SERDES_RST_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES     = 64,
  parameter int unsigned ALIGN_TIMEOUT     = 1024,
  parameter int unsigned MAX_RETRY         = 7,
  parameter int unsigned SKP_TIMEOUT       = 4096
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_enable,
  input  logic       i_phy_ready,
  input  logic [9:0] i_data,
  input  logic       i_align_run,
  input  logic       i_align_done,
  input  logic       i_align_fail,
  output logic       o_serdes_rst,
  output logic       o_align_start,
  output logic       o_link_up,
  output logic       o_link_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_loss_cnt,
  output logic [2:0] o_state
);

  localparam int unsigned WAIT_MAX = max3(SERDES_RST_CYCLES, SETTLE_CYCLES, ALIGN_TIMEOUT);
  localparam int unsigned WW       = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 2;

  localparam logic [WW-1:0] SRST_LAST   = WW'(SERDES_RST_CYCLES - 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] ALIGN_LAST  = WW'(ALIGN_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRY - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  logic rst_n, en_s, rdy_s, skp_timeout;
  logic align_armed, attempt_fail, attempt_done;

  link_state_e   state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;

  async_reset u_rst (.clk_i(i_clk), .arst_n_i(i_arst_n), .rst_n_o(rst_n));

  sync_2ff u_sync_en  (.clk_i(i_clk), .rst_n_i(rst_n), .d_i(i_enable),    .q_o(en_s));
  sync_2ff u_sync_rdy (.clk_i(i_clk), .rst_n_i(rst_n), .d_i(i_phy_ready), .q_o(rdy_s));

  phy_skp_monitor #(.SKP_TIMEOUT(SKP_TIMEOUT)) u_skp (
    .clk_i    (i_clk),
    .rst_n_i  (rst_n),
    .en_i     (state_q == ST_LINK_UP),
    .data_i   (i_data),
    .timeout_o(skp_timeout)
  );

  // The aligner still shows the previous attempt's sticky flags until it sees the start edge.
  assign align_armed  = (wait_q >= WW'(2));
  assign attempt_fail = (align_armed && i_align_fail) || (wait_q == ALIGN_LAST);
  assign attempt_done = align_armed && i_align_done && !i_align_run;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_IDLE:   if (en_s && rdy_s) state_d = ST_SRST;
      ST_SRST:   if (wait_q == SRST_LAST) state_d = ST_SETTLE;
      ST_SETTLE: if (wait_q == SETTLE_LAST) state_d = ST_ALIGN;
      ST_ALIGN: begin
        if (attempt_fail) begin
          if (retry_q == RETRY_LAST) begin
            state_d = ST_FAILED;
            retry_d = RETRY_MAX;
          end else begin
            state_d = ST_SRST;
            retry_d = retry_q + 1'b1;
          end
        end else if (attempt_done) begin
          state_d = ST_LINK_UP;
          retry_d = '0;
        end
      end
      ST_LINK_UP: begin
        if (skp_timeout) begin
          state_d = ST_SRST;
          retry_d = '0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      ST_FAILED: if (!en_s) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Losing enable or PHY clocking overrides anything decided above, including loss counting.
    if (state_q != ST_IDLE && !(en_s && rdy_s)) begin
      state_d = ST_IDLE;
      retry_d = '0;
      loss_d  = loss_q;
    end

    wait_d = wait_q + 1'b1;
    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_LINK_UP ||
        state_q == ST_FAILED) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  assign o_serdes_rst  = (state_q == ST_SRST);
  assign o_align_start = (state_q == ST_ALIGN);
  assign o_link_up     = (state_q == ST_LINK_UP);
  assign o_link_fail   = (state_q == ST_FAILED);
  assign o_retry_cnt   = retry_q;
  assign o_loss_cnt    = loss_q;
  assign o_state       = state_q;

endmodule
